instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: the request fields are valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: the encoder accepts a request this cycle.
REQ-005 SHALL have port code, input, 54 bits: one-hot instruction code.
- Bit map: 0-15 add,addu,sub,subu,and,or,xor,nor,slt,sltu,sll,srl,sra,sllv,srlv,srav.
- 16 jr; 17-28 addi,addiu,andi,ori,xori,lui,lw,sw,beq,bne,slti,sltiu; 29 j; 30 jal.
- 31 clz; 32 divu; 33 div; 34 mul; 35 multu; 36 jalr; 37 bgez; 38 lh; 39 lb; 40 lbu; 41 lhu; 42 sb; 43 sh.
- 44 mfc0; 45 mtc0; 46 mfhi; 47 mthi; 48 mflo; 49 mtlo; 50 eret; 51 syscall; 52 teq; 53 break.
REQ-006 SHALL have ports rs, rt, rd and shamt, input, 5 bits each: register and shift-amount fields.
REQ-007 SHALL have port imm, input, 16 bits: immediate or branch offset.
REQ-008 SHALL have port target, input, 26 bits: jump target field.
REQ-009 SHALL have port out_valid, output, 1 bit: instr holds a valid word.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer pops the word this cycle.
REQ-011 SHALL have port instr, output, 32 bits: the encoded MIPS32 word at the FIFO head.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse flagging a rejected code.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating count of rejected codes.
REQ-014 SHALL have port level, output, 3 bits: FIFO occupancy, 0 to 4.

Function
REQ-015 SHALL accept a request when in_valid and in_ready are both high; in_ready SHALL equal (level != 4), with no same-cycle pop bypass.
REQ-016 SHALL encode an accepted one-hot code in that same cycle and write the result to FIFO tail at the next edge.
- out_valid rises one cycle after acceptance into an empty FIFO.
REQ-017 SHALL build R-format words as {op, rs, rt, rd, shamt, funct}, with standard MIPS32 op and funct values.
- shamt is taken from the input for sll, srl and sra only; it is 0 for all other R-format codes.
- rs is forced to 0 for sll, srl and sra.
REQ-018 SHALL build I-format words as {op, rs, rt, imm} and J-format words (j, jal) as {op, target}.
REQ-019 SHALL apply these fixed-field overrides:
- bgez: rt = 00001.
- clz and mul: op = 011100.
- mfc0: word = {010000, 00000, rt, rd, 11'b0}.
- mtc0: word = {010000, 00100, rt, rd, 11'b0}.
- eret: word = 32'h42000018.
- syscall and break: code field = 0.
REQ-020 SHALL treat a code with zero bits set, or more than one bit set, as invalid when accepted.
- The request is consumed but not pushed to the FIFO.
- err pulses high for exactly one cycle, the cycle after acceptance.
- err_cnt increments and saturates at 255.
REQ-021 SHALL operate the 4-entry FIFO as follows:
- Pop when out_valid and out_ready are both high.
- Push and pop in the same cycle leave level unchanged.
- Read and write pointers wrap modulo 4.
- Popping from an empty FIFO has no effect.
REQ-022 SHALL drive out_valid = (level != 0) and instr = the head entry.
- instr is 0 whenever the FIFO is empty.
REQ-023 SHALL keep the head entry stable while out_valid is high and out_ready is low.

Reset
REQ-024 SHALL, on rst high at a clock edge, set the following at that edge:
- level, both pointers, err and err_cnt to 0.
- out_valid low and instr 0.
- in_ready high in the following cycle.
REQ-025 SHALL let reset override any simultaneous push, pop or error, discarding FIFO contents mid-operation.
REQ-026 SHALL leave in_ready low while rst is asserted.

Verification
REQ-027 SHALL cover R-format encoding:
- add, rs=1, rt=2, rd=3 -> instr 32'h00221820, one cycle after acceptance.
- sll, rt=1, rd=2, shamt=4 -> 32'h00011100.
REQ-028 SHALL cover I-format, J-format and fixed encodings:
- addi, rs=1, rt=2, imm=16'h0005 -> 32'h20220005.
- j, target=26'h100 -> 32'h08000100.
- eret -> 32'h42000018.
REQ-029 SHALL cover backpressure:
- Push 4 valid codes with out_ready=0 -> level=4 and in_ready=0; the 5th request is not accepted.
- Raise out_ready -> the 4 words are popped in push order.
REQ-030 SHALL cover invalid codes:
- code with bits 0 and 5 set, or code = 0 -> err pulses for 1 cycle, err_cnt increments, level unchanged.
- 300 invalid codes -> err_cnt = 255.
REQ-031 SHALL cover simultaneous events and reset:
- Push and pop in the same cycle at level=2 -> level stays 2.
- rst asserted at level=3 -> level=0, out_valid=0 and err_cnt=0 at the next edge.

Source files
------------

// File: rtl/instr_encoder.sv
// One-hot instruction request to MIPS32 word encoder with a 4-entry output FIFO.
// Malformed one-hot codes are dropped and reported on err / err_cnt.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [53:0] code,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [2:0]  level
);

    localparam logic [5:0] I_ADD     = 6'd0;
    localparam logic [5:0] I_ADDU    = 6'd1;
    localparam logic [5:0] I_SUB     = 6'd2;
    localparam logic [5:0] I_SUBU    = 6'd3;
    localparam logic [5:0] I_AND     = 6'd4;
    localparam logic [5:0] I_OR      = 6'd5;
    localparam logic [5:0] I_XOR     = 6'd6;
    localparam logic [5:0] I_NOR     = 6'd7;
    localparam logic [5:0] I_SLT     = 6'd8;
    localparam logic [5:0] I_SLTU    = 6'd9;
    localparam logic [5:0] I_SLL     = 6'd10;
    localparam logic [5:0] I_SRL     = 6'd11;
    localparam logic [5:0] I_SRA     = 6'd12;
    localparam logic [5:0] I_SLLV    = 6'd13;
    localparam logic [5:0] I_SRLV    = 6'd14;
    localparam logic [5:0] I_SRAV    = 6'd15;
    localparam logic [5:0] I_JR      = 6'd16;
    localparam logic [5:0] I_ADDI    = 6'd17;
    localparam logic [5:0] I_ADDIU   = 6'd18;
    localparam logic [5:0] I_ANDI    = 6'd19;
    localparam logic [5:0] I_ORI     = 6'd20;
    localparam logic [5:0] I_XORI    = 6'd21;
    localparam logic [5:0] I_LUI     = 6'd22;
    localparam logic [5:0] I_LW      = 6'd23;
    localparam logic [5:0] I_SW      = 6'd24;
    localparam logic [5:0] I_BEQ     = 6'd25;
    localparam logic [5:0] I_BNE     = 6'd26;
    localparam logic [5:0] I_SLTI    = 6'd27;
    localparam logic [5:0] I_SLTIU   = 6'd28;
    localparam logic [5:0] I_J       = 6'd29;
    localparam logic [5:0] I_JAL     = 6'd30;
    localparam logic [5:0] I_CLZ     = 6'd31;
    localparam logic [5:0] I_DIVU    = 6'd32;
    localparam logic [5:0] I_DIV     = 6'd33;
    localparam logic [5:0] I_MUL     = 6'd34;
    localparam logic [5:0] I_MULTU   = 6'd35;
    localparam logic [5:0] I_JALR    = 6'd36;
    localparam logic [5:0] I_BGEZ    = 6'd37;
    localparam logic [5:0] I_LH      = 6'd38;
    localparam logic [5:0] I_LB      = 6'd39;
    localparam logic [5:0] I_LBU     = 6'd40;
    localparam logic [5:0] I_LHU     = 6'd41;
    localparam logic [5:0] I_SB      = 6'd42;
    localparam logic [5:0] I_SH      = 6'd43;
    localparam logic [5:0] I_MFC0    = 6'd44;
    localparam logic [5:0] I_MTC0    = 6'd45;
    localparam logic [5:0] I_MFHI    = 6'd46;
    localparam logic [5:0] I_MTHI    = 6'd47;
    localparam logic [5:0] I_MFLO    = 6'd48;
    localparam logic [5:0] I_MTLO    = 6'd49;
    localparam logic [5:0] I_ERET    = 6'd50;
    localparam logic [5:0] I_SYSCALL = 6'd51;
    localparam logic [5:0] I_TEQ     = 6'd52;
    localparam logic [5:0] I_BREAK   = 6'd53;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_COP0     = 6'h10;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1c;

    logic        code_ok;
    logic [5:0]  code_idx;
    logic [19:0] r_fields;
    logic [25:0] i_fields;
    logic [14:0] sh_fields;
    logic [31:0] word;

    logic        accept;
    logic        push;
    logic        pop;
    logic        bad;

    logic [31:0] mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic        err_q;
    logic [7:0]  err_cnt_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign code_ok = (code != 54'd0) && ((code & (code - 54'd1)) == 54'd0);

    always_comb begin
        code_idx = 6'd0;
        for (int i = 0; i < 54; i++) begin
            if (code[i]) code_idx = i[5:0];
        end
    end

    assign r_fields  = {rs, rt, rd, 5'd0};
    assign i_fields  = {rs, rt, imm};
    assign sh_fields = {rt, rd, shamt};

    always_comb begin
        word = 32'd0;
        case (code_idx)
            I_ADD:     word = {OP_SPECIAL, r_fields, 6'h20};
            I_ADDU:    word = {OP_SPECIAL, r_fields, 6'h21};
            I_SUB:     word = {OP_SPECIAL, r_fields, 6'h22};
            I_SUBU:    word = {OP_SPECIAL, r_fields, 6'h23};
            I_AND:     word = {OP_SPECIAL, r_fields, 6'h24};
            I_OR:      word = {OP_SPECIAL, r_fields, 6'h25};
            I_XOR:     word = {OP_SPECIAL, r_fields, 6'h26};
            I_NOR:     word = {OP_SPECIAL, r_fields, 6'h27};
            I_SLT:     word = {OP_SPECIAL, r_fields, 6'h2a};
            I_SLTU:    word = {OP_SPECIAL, r_fields, 6'h2b};
            I_SLL:     word = {OP_SPECIAL, 5'd0, sh_fields, 6'h00};
            I_SRL:     word = {OP_SPECIAL, 5'd0, sh_fields, 6'h02};
            I_SRA:     word = {OP_SPECIAL, 5'd0, sh_fields, 6'h03};
            I_SLLV:    word = {OP_SPECIAL, r_fields, 6'h04};
            I_SRLV:    word = {OP_SPECIAL, r_fields, 6'h06};
            I_SRAV:    word = {OP_SPECIAL, r_fields, 6'h07};
            I_JR:      word = {OP_SPECIAL, r_fields, 6'h08};
            I_ADDI:    word = {6'h08, i_fields};
            I_ADDIU:   word = {6'h09, i_fields};
            I_ANDI:    word = {6'h0c, i_fields};
            I_ORI:     word = {6'h0d, i_fields};
            I_XORI:    word = {6'h0e, i_fields};
            I_LUI:     word = {6'h0f, i_fields};
            I_LW:      word = {6'h23, i_fields};
            I_SW:      word = {6'h2b, i_fields};
            I_BEQ:     word = {6'h04, i_fields};
            I_BNE:     word = {6'h05, i_fields};
            I_SLTI:    word = {6'h0a, i_fields};
            I_SLTIU:   word = {6'h0b, i_fields};
            I_J:       word = {6'h02, target};
            I_JAL:     word = {6'h03, target};
            I_CLZ:     word = {OP_SPECIAL2, r_fields, 6'h20};
            I_DIVU:    word = {OP_SPECIAL, r_fields, 6'h1b};
            I_DIV:     word = {OP_SPECIAL, r_fields, 6'h1a};
            I_MUL:     word = {OP_SPECIAL2, r_fields, 6'h02};
            I_MULTU:   word = {OP_SPECIAL, r_fields, 6'h19};
            I_JALR:    word = {OP_SPECIAL, r_fields, 6'h09};
            I_BGEZ:    word = {OP_REGIMM, rs, 5'b00001, imm};
            I_LH:      word = {6'h21, i_fields};
            I_LB:      word = {6'h20, i_fields};
            I_LBU:     word = {6'h24, i_fields};
            I_LHU:     word = {6'h25, i_fields};
            I_SB:      word = {6'h28, i_fields};
            I_SH:      word = {6'h29, i_fields};
            I_MFC0:    word = {OP_COP0, 5'b00000, rt, rd, 11'd0};
            I_MTC0:    word = {OP_COP0, 5'b00100, rt, rd, 11'd0};
            I_MFHI:    word = {OP_SPECIAL, r_fields, 6'h10};
            I_MTHI:    word = {OP_SPECIAL, r_fields, 6'h11};
            I_MFLO:    word = {OP_SPECIAL, r_fields, 6'h12};
            I_MTLO:    word = {OP_SPECIAL, r_fields, 6'h13};
            I_ERET:    word = 32'h4200_0018;
            I_SYSCALL: word = {OP_SPECIAL, 20'd0, 6'h0c};
            I_TEQ:     word = {OP_SPECIAL, r_fields, 6'h34};
            I_BREAK:   word = {OP_SPECIAL, 20'd0, 6'h0d};
            default:   word = 32'd0;
        endcase
    end

    // No pop bypass: a full FIFO refuses requests even if the head leaves this cycle.
    assign in_ready = !rst && (count != 3'd4);
    assign accept   = in_valid && in_ready;
    assign push     = accept && code_ok;
    assign bad      = accept && !code_ok;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            err_q <= bad;
            if (bad && (err_cnt_q != 8'hff)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= word;
    end

    assign out_valid = (count != 3'd0);
    assign instr     = out_valid ? mem[rd_ptr] : 32'd0;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign level     = count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed requests push expected words,
// a negedge monitor compares every word the DUT hands over.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [53:0] code;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_cnt;
    logic [2:0]  level;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        int          idx;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_w;
    } vec_t;

    vec_t vecs [13];

    instr_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .code      (code),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .imm       (imm),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .err_cnt   (err_cnt),
        .level     (level)
    );

    always #5 clk = ~clk;

    function automatic logic [53:0] oh(input int i);
        logic [53:0] v;
        v    = 54'd0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; holds the request over one edge.
    task automatic send(input logic [53:0] c, input logic [4:0] rs_i, input logic [4:0] rt_i,
                        input logic [4:0] rd_i, input logic [4:0] sh_i, input logic [15:0] imm_i,
                        input logic [25:0] tgt_i, input logic [31:0] exp_w, input bit good,
                        output bit acc);
        code     = c;
        rs       = rs_i;
        rt       = rt_i;
        rd       = rd_i;
        shamt    = sh_i;
        imm      = imm_i;
        target   = tgt_i;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (acc && good) exp_q.push_back(exp_w);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && level != 3'd0; k++) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drain_level", {29'd0, level}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_word: got %h, expected no word", instr);
            end else begin
                chk("fifo_word", instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;

        vecs[0]  = '{10, 5'd7,  5'd1,  5'd2,  5'd4, 16'h0000, 26'h0,       32'h0001_1100}; // sll
        vecs[1]  = '{17, 5'd1,  5'd2,  5'd9,  5'd3, 16'h0005, 26'h0,       32'h2022_0005}; // addi
        vecs[2]  = '{29, 5'd3,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h100,     32'h0800_0100}; // j
        vecs[3]  = '{50, 5'd5,  5'd6,  5'd0,  5'd0, 16'h0000, 26'h0,       32'h4200_0018}; // eret
        vecs[4]  = '{44, 5'd9,  5'd5,  5'd12, 5'd0, 16'h0000, 26'h0,       32'h4005_6000}; // mfc0
        vecs[5]  = '{45, 5'd0,  5'd5,  5'd12, 5'd0, 16'h0000, 26'h0,       32'h4085_6000}; // mtc0
        vecs[6]  = '{37, 5'd3,  5'd9,  5'd0,  5'd0, 16'h0010, 26'h0,       32'h0461_0010}; // bgez
        vecs[7]  = '{31, 5'd4,  5'd6,  5'd6,  5'd3, 16'h0000, 26'h0,       32'h7086_3020}; // clz
        vecs[8]  = '{51, 5'd1,  5'd2,  5'd3,  5'd1, 16'h0000, 26'h0,       32'h0000_000C}; // syscall
        vecs[9]  = '{24, 5'd29, 5'd31, 5'd0,  5'd0, 16'hfffc, 26'h0,       32'hAFBF_FFFC}; // sw
        vecs[10] = '{0,  5'd1,  5'd2,  5'd3,  5'd5, 16'h0000, 26'h0,       32'h0022_1820}; // add, shamt ignored
        vecs[11] = '{34, 5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 26'h0,       32'h7022_1802}; // mul
        vecs[12] = '{30, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'h3ffffff, 32'h0FFF_FFFF}; // jal

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; code = 54'd0;
        rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0; imm = 16'd0; target = 26'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();

        // add with consumer stalled: latency and head value
        send(oh(0), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h0022_1820, 1'b1, acc);
        chk("add_accepted", {31'd0, acc}, 32'd1);
        @(negedge clk);
        chk("add_out_valid", {31'd0, out_valid}, 32'd1);
        chk("add_level", {29'd0, level}, 32'd1);
        chk("add_instr", instr, 32'h0022_1820);
        step();
        out_ready = 1'b1;

        foreach (vecs[i]) begin
            send(oh(vecs[i].idx), vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].imm, vecs[i].tgt, vecs[i].exp_w, 1'b1, acc);
        end
        drain();

        // backpressure: fill, refuse 5th, then release in order
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(oh(0), 5'd1, 5'd2, 5'(i + 1), 5'd0, 16'd0, 26'd0,
                 32'h0022_0020 | (32'(i + 1) << 11), 1'b1, acc);
        end
        @(negedge clk);
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        send(oh(2), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h0022_1822, 1'b1, acc);
        chk("fifth_refused", {31'd0, acc}, 32'd0);
        @(negedge clk);
        chk("full_level_hold", {29'd0, level}, 32'd4);
        chk("full_head_stable", instr, 32'h0022_0820);
        step();
        out_ready = 1'b1;
        drain();

        // invalid codes with one valid word parked in the FIFO
        step();
        out_ready = 1'b0;
        send(oh(2), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'h0022_1822, 1'b1, acc);
        send(oh(0) | oh(5), 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 32'd0, 1'b0, acc);
        @(negedge clk);
        chk("two_hot_err", {31'd0, err}, 32'd1);
        chk("two_hot_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("two_hot_level", {29'd0, level}, 32'd1);
        @(negedge clk);
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        step();
        send(54'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 32'd0, 1'b0, acc);
        @(negedge clk);
        chk("zero_code_err", {31'd0, err}, 32'd1);
        chk("zero_code_err_cnt", {24'd0, err_cnt}, 32'd2);
        chk("zero_code_level", {29'd0, level}, 32'd1);
        step();
        out_ready = 1'b1;
        drain();

        // simultaneous push and pop at level 2
        step();
        out_ready = 1'b0;
        send(oh(17), 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 32'h2021_0001, 1'b1, acc);
        send(oh(17), 5'd1, 5'd1, 5'd0, 5'd0, 16'h0002, 26'd0, 32'h2021_0002, 1'b1, acc);
        out_ready = 1'b1;
        send(oh(17), 5'd1, 5'd1, 5'd0, 5'd0, 16'h0003, 26'd0, 32'h2021_0003, 1'b1, acc);
        out_ready = 1'b0;
        @(negedge clk);
        chk("push_pop_level", {29'd0, level}, 32'd2);
        step();
        send(oh(17), 5'd1, 5'd1, 5'd0, 5'd0, 16'h0004, 26'd0, 32'h2021_0004, 1'b1, acc);
        @(negedge clk);
        chk("pre_rst_level", {29'd0, level}, 32'd3);

        // reset while pushing, popping and with a non-zero error count
        step();
        rst       = 1'b1;
        in_valid  = 1'b1;
        code      = oh(0);
        out_ready = 1'b1;
        step();
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // 300 back-to-back invalid codes saturate err_cnt
        code     = 54'd0;
        in_valid = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("err_cnt_10", {24'd0, err_cnt}, 32'd10);
        repeat (290) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        chk("sat_level", {29'd0, level}, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
